// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: round-robin arbiter that owns the select/enable of a
// shared 3-to-8 decoder on behalf of eight requesters.
// Optional feature macro: ARB_TIMEOUT_EN adds a hold counter that forcibly
// revokes a grant after MAX_HOLD cycles and pulses `timeout`.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no grant held, arbitrate on every edge
// GRANT   | sel_en high, grant held until req[sel] drops (or hold limit)
// RELEASE | one-cycle gap with sel_en low; arbitration happens here

module decoder_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [2:0] sel,
    output logic       sel_en,
    output logic [7:0] grant,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("decoder_rr_arbiter: MAX_HOLD must be within 1..255");
    end

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] last_q, last_d;
    logic       sel_en_q, sel_en_d;
    logic [7:0] grant_q, grant_d;
    logic       timeout_q, timeout_d;

    logic [2:0]  search_base;
    logic [15:0] req_dbl;
    logic [7:0]  req_rot;
    logic [2:0]  win_off;
    logic [2:0]  winner;
    logic        any_req;
    logic        hold_expired;

    // Round-robin winner: rotate req so index last+1 lands at bit 0, take
    // the lowest set bit, then rotate the offset back.
    always_comb begin
        search_base = last_q + 3'd1;
        req_dbl     = {req, req};
        req_rot     = 8'(req_dbl >> search_base);
        win_off     = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_off = 3'(k);
            end
        end
        winner  = search_base + win_off;
        any_req = |req;
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_d;

    // Hold counter runs only while a grant continues; any other transition clears it.
    always_comb begin
        hold_d = 8'd0;
        if (state_q == GRANT && state_d == GRANT) begin
            hold_d = hold_q + 8'd1;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= 8'd0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign hold_expired = (hold_q == HOLD_LAST);
`else
    assign hold_expired = 1'b0;
`endif

    // Next-state and registered-output decisions.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        sel_en_d  = sel_en_q;
        grant_d   = grant_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE, RELEASE: begin
                if (any_req) begin
                    state_d  = GRANT;
                    sel_d    = winner;
                    last_d   = winner;
                    sel_en_d = 1'b1;
                    grant_d  = 8'b0000_0001 << winner;
                end else begin
                    state_d  = IDLE;
                    sel_en_d = 1'b0;
                    grant_d  = 8'd0;
                end
            end
            GRANT: begin
                // A voluntary drop wins over the hold limit, so no timeout then.
                if (!req[sel_q]) begin
                    state_d  = RELEASE;
                    sel_en_d = 1'b0;
                    grant_d  = 8'd0;
                end else if (hold_expired) begin
                    state_d   = RELEASE;
                    sel_en_d  = 1'b0;
                    grant_d   = 8'd0;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                sel_en_d = 1'b0;
                grant_d  = 8'd0;
            end
        endcase
    end

    // State and output registers; last resets to 7 so the first search starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= 3'd0;
            last_q    <= 3'd7;
            sel_en_q  <= 1'b0;
            grant_q   <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            sel_en_q  <= sel_en_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
        end
    end

    assign sel     = sel_q;
    assign sel_en  = sel_en_q;
    assign grant   = grant_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Testbench for decoder_rr_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
// Adapts to the ARB_TIMEOUT_EN build automatically.

module tb_decoder_rr_arbiter;

    localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [2:0] sel;
    logic       sel_en;
    logic [7:0] grant;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    decoder_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .sel    (sel),
        .sel_en (sel_en),
        .grant  (grant),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: who owns the decoder, for how many cycles, and who
    // was served last.
    int         m_owner;
    int         m_held;
    int         m_last;
    logic [2:0] m_sel;
    logic       m_to;

    function automatic void model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 7;
        m_sel   = 3'd0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_step(input logic [7:0] r);
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1;
            end else if (TO_EN && m_held >= MAX_HOLD) begin
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_held++;
            end
        end else begin
            for (int k = 1; k <= 8; k++) begin
                int idx;
                idx = (m_last + k) % 8;
                if (r[idx]) begin
                    m_owner = idx;
                    m_last  = idx;
                    m_sel   = 3'(idx);
                    m_held  = 1;
                    break;
                end
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string nm);
        logic       exp_en;
        logic [7:0] one;
        logic [7:0] exp_grant;
        exp_en    = (m_owner >= 0);
        one       = 8'd1;
        exp_grant = exp_en ? (one << m_sel) : 8'd0;
        chk({nm, " sel"}, 32'(sel), 32'(m_sel));
        chk({nm, " sel_en"}, 32'(sel_en), 32'(exp_en));
        chk({nm, " grant"}, 32'(grant), 32'(exp_grant));
        chk({nm, " timeout"}, 32'(timeout), 32'(m_to));
    endtask

    task automatic step(input logic [7:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 8'd0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset sel", 32'(sel), 32'd0);
        chk("reset sel_en", 32'(sel_en), 32'd0);
        chk("reset grant", 32'(grant), 32'd0);
        chk("reset timeout", 32'(timeout), 32'd0);
    endtask

    typedef struct {
        logic [7:0] req;
        logic [2:0] sel;
        logic       en;
        logic [7:0] grant;
        logic       to;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [7:0] r;
        logic [7:0] pat;
        logic [7:0] one;
        int         exp_w;

        // Idle, single requester 2 for three cycles, then a handoff to 3 and 1.
        for (int i = 0; i < 5; i++) tbl[i] = '{8'h00, 3'd0, 1'b0, 8'h00, 1'b0};
        tbl[5]  = '{8'h04, 3'd2, 1'b1, 8'h04, 1'b0};
        tbl[6]  = '{8'h04, 3'd2, 1'b1, 8'h04, 1'b0};
        tbl[7]  = '{8'h04, 3'd2, 1'b1, 8'h04, 1'b0};
        tbl[8]  = '{8'h00, 3'd2, 1'b0, 8'h00, 1'b0};
        tbl[9]  = '{8'h00, 3'd2, 1'b0, 8'h00, 1'b0};
        tbl[10] = '{8'h0A, 3'd3, 1'b1, 8'h08, 1'b0};
        tbl[11] = '{8'h02, 3'd3, 1'b0, 8'h00, 1'b0};
        tbl[12] = '{8'h02, 3'd1, 1'b1, 8'h02, 1'b0};

        rst_n = 1'b0;
        req   = 8'd0;
        model_reset();
        #12;
        do_reset();

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].req);
            chk($sformatf("vec%0d sel", i), 32'(sel), 32'(tbl[i].sel));
            chk($sformatf("vec%0d sel_en", i), 32'(sel_en), 32'(tbl[i].en));
            chk($sformatf("vec%0d grant", i), 32'(grant), 32'(tbl[i].grant));
            chk($sformatf("vec%0d timeout", i), 32'(timeout), 32'(tbl[i].to));
        end

        // Requesters 0 and 7 take turns, each with a single idle gap.
        do_reset();
        one = 8'd1;
        for (int g = 0; g < 4; g++) begin
            exp_w = (g % 2 == 0) ? 0 : 7;
            step(8'h81);
            chk($sformatf("alt%0d first sel", g), 32'(sel), 32'(exp_w));
            chk($sformatf("alt%0d first en", g), 32'(sel_en), 32'd1);
            step(8'h81);
            chk($sformatf("alt%0d second en", g), 32'(sel_en), 32'd1);
            pat = 8'h81 & ~(one << exp_w);
            step(pat);
            chk($sformatf("alt%0d gap en", g), 32'(sel_en), 32'd0);
            chk_model($sformatf("alt%0d", g));
        end

        // Requester 5 never lets go.
        do_reset();
`ifdef ARB_TIMEOUT_EN
        for (int rep = 0; rep < 2; rep++) begin
            for (int c = 0; c < MAX_HOLD; c++) begin
                step(8'h20);
                chk($sformatf("hold r%0d c%0d en", rep, c), 32'(sel_en), 32'd1);
                chk($sformatf("hold r%0d c%0d sel", rep, c), 32'(sel), 32'd5);
                chk($sformatf("hold r%0d c%0d to", rep, c), 32'(timeout), 32'd0);
            end
            step(8'h20);
            chk($sformatf("revoke r%0d en", rep), 32'(sel_en), 32'd0);
            chk($sformatf("revoke r%0d to", rep), 32'(timeout), 32'd1);
            chk($sformatf("revoke r%0d grant", rep), 32'(grant), 32'd0);
        end
        step(8'h20);
        chk("regrant sel", 32'(sel), 32'd5);
        chk("regrant to", 32'(timeout), 32'd0);
`else
        for (int c = 0; c < 12; c++) begin
            step(8'h20);
            chk($sformatf("hold c%0d en", c), 32'(sel_en), 32'd1);
            chk($sformatf("hold c%0d sel", c), 32'(sel), 32'd5);
            chk($sformatf("hold c%0d to", c), 32'(timeout), 32'd0);
        end
`endif

        // Reset pulled while requester 3 holds the grant.
        do_reset();
        step(8'h08);
        chk("pre-rst sel", 32'(sel), 32'd3);
        step(8'h09);
        chk("pre-rst en", 32'(sel_en), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async rst sel_en", 32'(sel_en), 32'd0);
        chk("async rst grant", 32'(grant), 32'd0);
        chk("async rst sel", 32'(sel), 32'd0);
        chk("async rst timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h09);
        chk("post-rst sel", 32'(sel), 32'd0);
        chk("post-rst grant", 32'(grant), 32'd1);
        chk("post-rst to", 32'(timeout), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        r = 8'd0;
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(7))
                0: r = 8'($urandom);
                1: r = 8'($urandom) & 8'($urandom);
                2: r = r & 8'($urandom);
                default: ;
            endcase
            step(r);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
